// File: rtl/ahb_pack.sv
// Shared AHB type definitions used by managers, subordinates and benches.
// Latency: none (types only).
// Backpressure: none (types only).
package ahb_pack;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } t_htrans;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } t_hsize;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } t_hresp;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } t_hburst;

    // Data-phase sequencer states of the SRAM subordinate.
    typedef enum logic [1:0] {
        SUB_IDLE = 2'd0,
        SUB_WAIT = 2'd1,
        SUB_ERR1 = 2'd2,
        SUB_ERR2 = 2'd3
    } t_sub_state;

endpackage

// File: rtl/ahb_sub_bytemem.sv
// Word-organised SRAM with per-byte write enables and a registered read port.
// Latency: read data appears one cycle after i_rd_en; writes land at the clock edge.
// Backpressure: none; the read register holds its value while i_rd_en is low.
module ahb_sub_bytemem
    import ahb_pack::*;
#(
    parameter int DATA_WDT  = 32,
    parameter int MEM_DEPTH = 64,
    localparam int NB       = DATA_WDT / 8,
    localparam int AW       = $clog2(MEM_DEPTH)
)(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_idx,
    input  logic [NB-1:0]       i_wr_be,
    input  logic [DATA_WDT-1:0] i_wr_dat,
    input  logic                i_rd_en,
    input  logic [AW-1:0]       i_rd_idx,
    output logic [DATA_WDT-1:0] o_rd_dat
);

    logic [DATA_WDT-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WDT-1:0] r_rd_dat;

    // Byte-lane write; array contents deliberately have no reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_idx][8*b +: 8] <= i_wr_dat[8*b +: 8];
                end
            end
        end
    end

    // Registered read port, cleared by reset, held when no read is issued.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_dat <= '0;
        end else if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB subordinate in front of a byte-addressable SRAM with fixed wait states and ERROR on illegal access.
// Latency: data phase completes WAIT_STATES cycles after the first data cycle; errors take two cycles.
// Backpressure: o_hreadyout low during wait states and the first ERROR cycle; otherwise full rate.
module ahb_sram_subordinate
    import ahb_pack::*;
#(
    parameter int          DATA_WDT    = 32,
    parameter int          MEM_DEPTH   = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h100,
    parameter int          WAIT_STATES = 0
)(
    input  logic                i_hclk,
    input  logic                i_hreset,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  t_htrans             i_htrans,
    input  logic                i_hwrite,
    input  t_hsize              i_hsize,
    input  t_hburst             i_hburst,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_hready,
    output logic [DATA_WDT-1:0] o_hrdata,
    output logic                o_hreadyout,
    output t_hresp              o_hresp
);

    localparam int NB        = DATA_WDT / 8;
    localparam int LW        = $clog2(NB);
    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int MEM_BYTES = MEM_DEPTH * NB;

    t_sub_state          r_state, w_state_nxt;
    logic [2:0]          r_cnt, w_cnt_nxt;
    logic                w_rdy_state, w_accept, w_legal;
    logic [31:0]         w_off;
    logic [AW-1:0]       w_idx;
    logic [LW-1:0]       w_lo;
    logic [NB-1:0]       w_be;
    logic                r_dp_vld, r_dp_write;
    logic [AW-1:0]       r_dp_idx;
    logic [NB-1:0]       r_dp_be;
    logic                w_wr_en, w_rd_en, w_hazard;
    logic [NB-1:0]       r_fwd_be;
    logic [DATA_WDT-1:0] r_fwd_dat;
    logic [DATA_WDT-1:0] w_mem_rd_dat;
    logic                w_unused;

    // Burst type does not affect decode; each beat is handled on its own address.
    assign w_unused = ^{i_hburst};

    // Address phases are only sampled in states that drive HREADYOUT high.
    assign w_rdy_state = (r_state == SUB_IDLE) || (r_state == SUB_ERR2);
    assign w_accept    = w_rdy_state && i_hsel && i_hready &&
                         ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));

    // Out-of-range addresses below the base wrap to large offsets and fail the range test.
    assign w_off   = i_haddr - BASE_ADDR;
    assign w_legal = (w_off < 32'(MEM_BYTES)) &&
                     ((i_haddr & ((32'd1 << i_hsize) - 32'd1)) == 32'd0) &&
                     ((32'd8 << i_hsize) <= 32'(DATA_WDT));
    assign w_idx   = w_off[LW +: AW];
    assign w_lo    = i_haddr[LW-1:0];

    // Byte lanes touched by the transfer: [addr_lo +: 1<<size].
    always_comb begin
        w_be = '0;
        for (int i = 0; i < NB; i++) begin
            w_be[i] = (i >= int'(w_lo)) && (i < int'(w_lo) + (1 << i_hsize));
        end
    end

    // A write retires in the IDLE cycle that ends its data phase.
    assign w_wr_en  = (r_state == SUB_IDLE) && r_dp_vld && r_dp_write;
    assign w_rd_en  = w_accept && w_legal && !i_hwrite;
    assign w_hazard = w_rd_en && w_wr_en && (w_idx == r_dp_idx);

    // State and wait counter registers.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state <= SUB_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: decode new address phases, count wait states, sequence the two ERROR cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            SUB_IDLE, SUB_ERR2: begin
                w_state_nxt = SUB_IDLE;
                if (w_accept) begin
                    if (!w_legal) begin
                        w_state_nxt = SUB_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nxt = SUB_WAIT;
                        w_cnt_nxt   = 3'(WAIT_STATES);
                    end
                end
            end
            SUB_WAIT: begin
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = SUB_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            SUB_ERR1: w_state_nxt = SUB_ERR2;
            default:  w_state_nxt = SUB_IDLE;
        endcase
    end

    // Capture the accepted address phase for use in its data phase; reset drops any pending write.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_dp_vld   <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_idx   <= '0;
            r_dp_be    <= '0;
        end else if (w_rdy_state) begin
            r_dp_vld <= w_accept && w_legal;
            if (w_accept) begin
                r_dp_write <= i_hwrite;
                r_dp_idx   <= w_idx;
                r_dp_be    <= w_be;
            end
        end
    end

    // Snapshot write bytes that retire to the same word a read is fetching this cycle.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_fwd_be  <= '0;
            r_fwd_dat <= '0;
        end else if (w_rd_en) begin
            r_fwd_be  <= w_hazard ? r_dp_be : '0;
            r_fwd_dat <= i_hwdata;
        end
    end

    ahb_sub_bytemem #(
        .DATA_WDT  (DATA_WDT),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .i_clk    (i_hclk),
        .i_rst    (i_hreset),
        .i_wr_en  (w_wr_en),
        .i_wr_idx (r_dp_idx),
        .i_wr_be  (r_dp_be),
        .i_wr_dat (i_hwdata),
        .i_rd_en  (w_rd_en),
        .i_rd_idx (w_idx),
        .o_rd_dat (w_mem_rd_dat)
    );

    // Merge forwarded write bytes over the registered memory word; both sources are registers.
    always_comb begin
        o_hrdata = '0;
        for (int i = 0; i < NB; i++) begin
            o_hrdata[8*i +: 8] = r_fwd_be[i] ? r_fwd_dat[8*i +: 8] : w_mem_rd_dat[8*i +: 8];
        end
    end

    assign o_hreadyout = w_rdy_state;
    assign o_hresp     = ((r_state == SUB_ERR1) || (r_state == SUB_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule
